bcd_seg_scanner: RTL
====================

Name: bcd_seg_scanner

Overview:
- Downstream consumer of the counter/bin2bcd path: takes the packed BCD count and drives a time-multiplexed common-anode-style 7-segment display, one digit at a time.
- A valid/ready handshake captures new values into a pending buffer. The pending value is promoted to the display register only at a frame boundary, so a digit never changes mid-scan.

Parameters:
- DIGITS, 3, number of BCD digits displayed (input width 4*DIGITS).
- SCAN_DIV, 1000, clk cycles per digit slot (>=2).
- DIV_WIDTH, 16, prescaler width; must satisfy 2**DIV_WIDTH >= SCAN_DIV.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, scan enable; low = display dark and prescaler frozen.
- bcd, input, 4*DIGITS, packed BCD; nibble 0 = least significant digit.
- bcd_valid, input, 1, bcd holds a value to capture.
- bcd_ready, output, 1, pending buffer empty; capture occurs on valid && ready at the clk edge.
- an, output, DIGITS, one-hot digit select, active-high; an[0] = least significant digit.
- seg, output, 7, segments {g,f,e,d,c,b,a}, active-high.
- frame_done, output, 1, one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst sampled high at the edge):
  - prescaler=0, idx=0, display reg=0, pending empty.
  - an=0, seg=0, frame_done=0.
  - bcd_ready = !pend_full && !rst, so it is 0 while rst is high and 1 in the first cycle after.
- Prescaler:
  - While en=1, counts 0..SCAN_DIV-1 and wraps.
  - tick = (en && prescaler==SCAN_DIV-1).
  - While en=0, the prescaler holds.
- Digit index:
  - On tick, idx advances 0→1→…→DIGITS-1→0.
  - Frame boundary = tick && idx==DIGITS-1.
  - frame_done is registered: high exactly one cycle, the cycle after the boundary edge.
- Outputs:
  - Registered, one-cycle latency from idx/display reg.
  - en=1: an = 1<<idx, seg = decode(display nibble idx).
  - en=0: an=0, seg=0.
- Decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F. Any nibble >9 gives 40 (dash).
- Handshake:
  - valid && ready → bcd copied to pending, pend_full=1; ready falls the next cycle.
  - bcd_valid is ignored while pend_full=1.
  - At a frame boundary with pend_full=1: display ← pending, pend_full=0; ready rises the next cycle.
- Simultaneous events:
  - Capture at the same edge as a boundary with pending empty: the value goes to pending only (no bypass) and displays after the next boundary.
  - Boundary while pend_full and valid high: the transfer happens and valid is not accepted that cycle.
- Reset mid-frame: the pending value is discarded and all state returns to reset values.
- en toggling does not affect the handshake; pending waits for the next boundary, which needs en=1.

Optional Feature:
- Macro SEG_LZB_EN enables leading-zero blanking.
- Defined: for digit k>0, seg=0 (an still asserted) when display nibbles k..DIGITS-1 are all 0. Digit 0 is never blanked, so 000 shows "0".
- Undefined: every digit is always decoded.

Decomposition:
- Package bcd_seg_pkg:
  - seg_t (logic [6:0]).
  - SEG_0..SEG_9 and SEG_DASH constants.
  - BLANK constant (7'h00).
- One sub-module, seg7_decode: combinational nibble → seg_t.
- Prescaler, scan FSM, handshake and blanking stay in bcd_seg_scanner.

Test Plan (DIGITS=3, SCAN_DIV=4):
- Reset then en=1, no load → first edge after reset gives an=001, seg=3F. an steps 001→010→100 every 4 cycles; frame_done pulses every 12 cycles.
- Pulse valid with bcd=12'h255 → ready=0 next cycle. After the next frame_done, digits 0/1/2 show 6D/6D/5B and ready=1 again.
- Hold valid with 12'h123 then 12'h456 → 123 is captured, ready=0, 456 is not accepted. 456 is accepted the cycle after transfer and appears one frame after 123.
- bcd=12'h0A3 → digit1 seg=40, digit0 seg=4F, digit2 seg=3F (LZB off).
- SEG_LZB_EN defined, bcd=12'h007 → digit2/1 seg=00 with an asserted, digit0 seg=07. With 12'h000, digit0 seg=3F.
- Reset asserted mid-frame with pend_full=1 → next edge gives an=0, seg=0, ready=0. After release the display shows 0 and the pending value is lost.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// Shared types and segment constants for the BCD 7-segment scanner.
// Segment order is {g,f,e,d,c,b,a}, active-high.
package bcd_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0    = 7'h3F;
  localparam seg_t SEG_1    = 7'h06;
  localparam seg_t SEG_2    = 7'h5B;
  localparam seg_t SEG_3    = 7'h4F;
  localparam seg_t SEG_4    = 7'h66;
  localparam seg_t SEG_5    = 7'h6D;
  localparam seg_t SEG_6    = 7'h7D;
  localparam seg_t SEG_7    = 7'h07;
  localparam seg_t SEG_8    = 7'h7F;
  localparam seg_t SEG_9    = 7'h6F;
  localparam seg_t SEG_DASH = 7'h40;
  localparam seg_t BLANK    = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder. Non-decimal nibbles
// (A..F) render as a centre dash so corrupted counts are visible.
module seg7_decode
  import bcd_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Nibble lookup; anything outside 0..9 shows a dash.
  always_comb begin
    seg = SEG_DASH;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed 7-segment driver for a packed BCD count.
// A valid/ready handshake fills a one-entry pending buffer; the pending
// value is promoted to the display register only at a frame boundary so
// no digit changes in the middle of a scan.
// Optional build macro: SEG_LZB_EN enables leading-zero blanking
// (digit 0 is never blanked).
module bcd_seg_scanner
  import bcd_seg_pkg::*;
#(
  parameter int DIGITS    = 3,
  parameter int SCAN_DIV  = 1000,
  parameter int DIV_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic                  bcd_valid,
  output logic                  bcd_ready,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(DIGITS - 1);

  logic [DIV_WIDTH-1:0]  presc_r;
  logic [IDX_W-1:0]      idx_r;
  logic [4*DIGITS-1:0]   disp_r;
  logic [4*DIGITS-1:0]   pend_r;
  logic                  pend_full_r;
  logic [DIGITS-1:0]     an_r;
  seg_t                  seg_r;
  logic                  frame_done_r;

  logic                  tick_s;
  logic                  boundary_s;
  logic [3:0]            nib_s;
  seg_t                  dec_s;
  logic                  sel_blank_s;
  logic [DIGITS-1:0]     an_next_s;

  assign tick_s     = en && (presc_r == PRESC_LAST);
  assign boundary_s = tick_s && (idx_r == IDX_LAST);

  // Ready is combinational on purpose: it must read low during reset.
  assign bcd_ready  = !pend_full_r && !rst;
  assign an         = an_r;
  assign seg        = seg_r;
  assign frame_done = frame_done_r;

  // Prescaler: counts enabled cycles within one digit slot, frozen when en=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {DIV_WIDTH{1'b0}};
    end else if (en) begin
      presc_r <= (presc_r == PRESC_LAST) ? {DIV_WIDTH{1'b0}}
                                         : presc_r + DIV_WIDTH'(1);
    end else begin
      presc_r <= presc_r;
    end
  end

  // Digit index: advances one slot per prescaler wrap, wraps after the top digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= {IDX_W{1'b0}};
    end else if (tick_s) begin
      idx_r <= (idx_r == IDX_LAST) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      idx_r <= idx_r;
    end
  end

  // Handshake: frame-boundary promotion has priority; capture only when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r      <= {(4*DIGITS){1'b0}};
      pend_r      <= {(4*DIGITS){1'b0}};
      pend_full_r <= 1'b0;
    end else if (boundary_s && pend_full_r) begin
      disp_r      <= pend_r;
      pend_r      <= pend_r;
      pend_full_r <= 1'b0;
    end else if (bcd_valid && !pend_full_r) begin
      disp_r      <= disp_r;
      pend_r      <= bcd;
      pend_full_r <= 1'b1;
    end else begin
      disp_r      <= disp_r;
      pend_r      <= pend_r;
      pend_full_r <= pend_full_r;
    end
  end

  // Select the display nibble for the digit currently being scanned.
  always_comb begin
    nib_s = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      nib_s = (idx_r == IDX_W'(k)) ? disp_r[4*k +: 4] : nib_s;
    end
  end

  seg7_decode u_dec (
    .nibble (nib_s),
    .seg    (dec_s)
  );

`ifdef SEG_LZB_EN
  // Leading-zero blanking: digit k>0 goes dark when it and every higher digit are zero.
  always_comb begin
    logic zero_above;
    zero_above  = 1'b1;
    sel_blank_s = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above  = zero_above && (disp_r[4*k +: 4] == 4'h0);
      sel_blank_s = (idx_r == IDX_W'(k)) ? zero_above : sel_blank_s;
    end
  end
`else
  // No blanking in this build: every digit is always decoded.
  always_comb begin
    sel_blank_s = 1'b0;
  end
`endif

  // One-hot anode for the current digit.
  always_comb begin
    an_next_s = DIGITS'(1) << idx_r;
  end

  // Registered outputs: one cycle behind idx/display; dark when disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_r         <= {DIGITS{1'b0}};
      seg_r        <= BLANK;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= boundary_s;
      if (en) begin
        an_r  <= an_next_s;
        seg_r <= sel_blank_s ? BLANK : dec_s;
      end else begin
        an_r  <= {DIGITS{1'b0}};
        seg_r <= BLANK;
      end
    end
  end

endmodule
